// File: rtl/tristate_bus_arbiter_if.sv
// Request/bus bundle shared by the producers and the tri-state bus arbiter.
// The arbiter takes the slave side. The bus itself is a net so that undriven bits resolve to Z.
interface tristate_bus_arbiter_if #(
  parameter int WIDTH = 21,
  parameter int N_CH  = 4
);
  localparam int OWNER_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]       req_valid;
  logic [N_CH*WIDTH-1:0] req_data;
  logic [N_CH*WIDTH-1:0] req_mask;
  logic [N_CH-1:0]       req_ready;
  wire  [WIDTH-1:0]      bus;
  logic                  bus_valid;
  logic [OWNER_W-1:0]    bus_owner;

  modport master (
    output req_valid, req_data, req_mask,
    input  req_ready, bus, bus_valid, bus_owner
  );

  modport slave (
    input  req_valid, req_data, req_mask,
    output req_ready, bus, bus_valid, bus_owner
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter that shares one tri-stated bus among N_CH channels.
// Each granted word is held for HOLD cycles, followed by TURN all-Z cycles.
module tristate_bus_arbiter #(
  parameter int WIDTH = 21,
  parameter int N_CH  = 4,
  parameter int HOLD  = 1,
  parameter int TURN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tristate_bus_arbiter_if.slave bif
);
  localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_MAX = (HOLD > TURN) ? HOLD : TURN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] owner_reg, owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  int               scan_idx;

  // First valid channel starting at ptr, wrapping modulo N_CH.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = (int'(ptr_reg) + k) % N_CH;
      if (!grant_any && bif.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    mask_next  = mask_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_any) begin
          data_next  = bif.req_data[grant_idx*WIDTH +: WIDTH];
          mask_next  = bif.req_mask[grant_idx*WIDTH +: WIDTH];
          owner_next = grant_idx;
          ptr_next   = PTR_W'((int'(grant_idx) + 1) % N_CH);
          cnt_next   = CNT_W'(HOLD - 1);
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_reg == '0) begin
          if (TURN > 0) begin
            state_next = ST_TURN;
            cnt_next   = CNT_W'(TURN - 1);
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_TURN: begin
        if (cnt_reg == '0) state_next = ST_IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      mask_reg  <= mask_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign bif.req_ready[gi] = !rst && (state_reg == ST_IDLE) && grant_any
                                 && (grant_idx == PTR_W'(gi));
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_bus
      assign bif.bus[gi] = ((state_reg == ST_DRIVE) && mask_reg[gi]) ? data_reg[gi] : 1'bz;
    end
  endgenerate

  assign bif.bus_valid = (state_reg == ST_DRIVE);
  assign bif.bus_owner = owner_reg;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: one instance with HOLD=2/TURN=1 and one with HOLD=1/TURN=0.
module tb_tristate_bus_arbiter;
  localparam int W = 21;
  localparam logic [W-1:0] ONES = 21'h1FFFFF;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.WIDTH(W), .N_CH(4)) bif0 ();
  tristate_bus_arbiter_if #(.WIDTH(W), .N_CH(4)) bif1 ();

  tristate_bus_arbiter #(.WIDTH(W), .N_CH(4), .HOLD(2), .TURN(1)) u0 (
    .clk(clk), .rst(rst), .bif(bif0.slave)
  );
  tristate_bus_arbiter #(.WIDTH(W), .N_CH(4), .HOLD(1), .TURN(0)) u1 (
    .clk(clk), .rst(rst), .bif(bif1.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [W-1:0] exp_bus(input logic [W-1:0] d, input logic [W-1:0] m);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = m[i] ? d[i] : 1'bz;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch0(input int ch, input logic v, input logic [W-1:0] d, input logic [W-1:0] m);
    bif0.req_valid[ch]        = v;
    bif0.req_data[ch*W +: W]  = d;
    bif0.req_mask[ch*W +: W]  = m;
  endtask

  initial begin
    rst = 1'b1;
    bif0.req_valid = '0; bif0.req_data = '0; bif0.req_mask = '0;
    bif1.req_valid = '0; bif1.req_data = '0; bif1.req_mask = '0;
    step();

    // Reset held with random request traffic: ready must stay low.
    for (int i = 0; i < 3; i++) begin
      bif0.req_valid = 4'($urandom);
      bif0.req_data  = {$urandom, $urandom, $urandom};
      bif0.req_mask  = {$urandom, $urandom, $urandom};
      bif1.req_valid = 4'($urandom);
      #1;
      check_val("rst_ready0", 32'(bif0.req_ready), 32'h0);
      check_val("rst_ready1", 32'(bif1.req_ready), 32'h0);
      step();
    end
    rst = 1'b0;
    bif0.req_valid = '0; bif0.req_data = '0; bif0.req_mask = '0;
    bif1.req_valid = '0;
    #1;
    check_val("post_rst_bus", 32'(bif0.bus), 32'(exp_bus('0, '0)));
    check_val("post_rst_valid", 32'(bif0.bus_valid), 32'h0);
    check_val("post_rst_ready", 32'(bif0.req_ready), 32'h0);
    check_val("post_rst_owner", 32'(bif0.bus_owner), 32'h0);

    // Single request on ch2; data changes after handshake must not reach the bus.
    set_ch0(2, 1'b1, 21'd32, ONES);
    #1;
    check_val("single_ready", 32'(bif0.req_ready), 32'b0100);
    step();
    set_ch0(2, 1'b0, 21'h0ABCD, 21'h0);
    for (int c = 1; c <= 2; c++) begin
      #1;
      check_val("single_bus", 32'(bif0.bus), 32'd32);
      check_val("single_valid", 32'(bif0.bus_valid), 32'h1);
      check_val("single_owner", 32'(bif0.bus_owner), 32'd2);
      step();
    end
    check_val("single_turn_bus", 32'(bif0.bus), 32'(exp_bus('0, '0)));
    check_val("single_turn_valid", 32'(bif0.bus_valid), 32'h0);
    check_val("single_turn_ready", 32'(bif0.req_ready), 32'h0);
    step();

    // Partial masks on ch0 (ptr=3 then ptr=1, ch0 wins both times).
    set_ch0(0, 1'b1, 21'd64, 21'h40);
    #1;
    check_val("pmask_ready", 32'(bif0.req_ready), 32'b0001);
    step();
    set_ch0(0, 1'b0, 21'd0, 21'd0);
    check_val("pmask_bus_c1", 32'(bif0.bus), 32'(exp_bus(21'd64, 21'h40)));
    step();
    check_val("pmask_bus_c2", 32'(bif0.bus), 32'(exp_bus(21'd64, 21'h40)));
    step(); step();
    set_ch0(0, 1'b1, ONES, 21'h40);
    #1;
    check_val("pmask2_ready", 32'(bif0.req_ready), 32'b0001);
    step();
    set_ch0(0, 1'b0, 21'd0, 21'd0);
    check_val("pmask2_bus", 32'(bif0.bus), 32'(exp_bus(ONES, 21'h40)));
    step(); step(); step();
    set_ch0(0, 1'b1, ONES, 21'h0);
    #1;
    check_val("zmask_ready", 32'(bif0.req_ready), 32'b0001);
    step();
    set_ch0(0, 1'b0, 21'd0, 21'd0);
    check_val("zmask_bus", 32'(bif0.bus), 32'(exp_bus('0, '0)));
    check_val("zmask_valid", 32'(bif0.bus_valid), 32'h1);
    step(); step(); step();

    // Round-robin from a fresh pointer, all channels continuously valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ch0(i, 1'b1, W'(i + 1), ONES);
    #1;
    for (int g = 0; g < 5; g++) begin
      check_val($sformatf("rr_ready_%0d", g), 32'(bif0.req_ready), 32'(1 << (g % 4)));
      step();
      check_val($sformatf("rr_bus_%0d", g), 32'(bif0.bus), 32'((g % 4) + 1));
      check_val($sformatf("rr_owner_%0d", g), 32'(bif0.bus_owner), 32'(g % 4));
      step();
      check_val($sformatf("rr_bus2_%0d", g), 32'(bif0.bus), 32'((g % 4) + 1));
      step();
      check_val($sformatf("rr_turn_%0d", g), 32'(bif0.bus), 32'(exp_bus('0, '0)));
      step();
    end

    // Reset during ch3's first DRIVE cycle; afterwards ch1 wins from ptr=0.
    bif0.req_valid = '0;
    set_ch0(3, 1'b1, 21'h15555, ONES);
    #1;
    check_val("mid_ready_ch3", 32'(bif0.req_ready), 32'b1000);
    step();
    rst = 1'b1;
    set_ch0(1, 1'b1, 21'h0000A, ONES);
    #1;
    check_val("mid_drive_bus", 32'(bif0.bus), 32'h15555);
    check_val("mid_rst_ready", 32'(bif0.req_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check_val("mid_after_bus", 32'(bif0.bus), 32'(exp_bus('0, '0)));
    check_val("mid_after_valid", 32'(bif0.bus_valid), 32'h0);
    check_val("mid_after_owner", 32'(bif0.bus_owner), 32'h0);
    check_val("mid_after_ready", 32'(bif0.req_ready), 32'b0010);
    step();
    bif0.req_valid = '0;
    check_val("mid_ch1_bus", 32'(bif0.bus), 32'h0000A);
    check_val("mid_ch1_owner", 32'(bif0.bus_owner), 32'h1);
    step(); step(); step();

    // HOLD=1, TURN=0 instance: ch1 continuously valid, grant every 2 cycles.
    bif1.req_valid = 4'b0010;
    bif1.req_data  = '0;
    bif1.req_mask  = '0;
    bif1.req_data[1*W +: W] = 21'd7;
    bif1.req_mask[1*W +: W] = ONES;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_val($sformatf("t0_ready_%0d", g), 32'(bif1.req_ready), 32'b0010);
      check_val($sformatf("t0_idle_bus_%0d", g), 32'(bif1.bus), 32'(exp_bus('0, '0)));
      step();
      check_val($sformatf("t0_bus_%0d", g), 32'(bif1.bus), 32'd7);
      check_val($sformatf("t0_valid_%0d", g), 32'(bif1.bus_valid), 32'h1);
      check_val($sformatf("t0_busy_ready_%0d", g), 32'(bif1.req_ready), 32'h0);
      step();
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif1.req_valid = '0;
    #1;
    check_val("t0_rst_bus", 32'(bif1.bus), 32'(exp_bus('0, '0)));
    check_val("t0_rst_valid", 32'(bif1.bus_valid), 32'h0);
    step();
    check_val("t0_idle_bus", 32'(bif1.bus), 32'(exp_bus('0, '0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Parametrised successor to the team's combinational tri-state buffer. It shares one tri-stated, WIDTH-bit bus among N_CH requesting channels. Each channel presents a data word and a per-bit drive mask under a valid/ready handshake; a round-robin arbiter grants one channel, and the captured word is driven for HOLD cycles, followed by TURN all-Z turnaround cycles. The block sits between neuron-side producers and a shared broadcast bus in the DigitalNeuron datapath.

## Interface
- WIDTH, 21, bus and data width in bits
- N_CH, 4, number of requesting channels (≥1)
- HOLD, 1, cycles each granted word is driven (≥1)
- TURN, 1, all-Z turnaround cycles between owners (≥0)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  N_CH  channel i has a word to send
- req_data  input  N_CH*WIDTH  channel i data in bits [i*WIDTH +: WIDTH]
- req_mask  input  N_CH*WIDTH  channel i drive mask in the same slice; bit=1 drives, bit=0 leaves Z
- req_ready  output  N_CH  one-hot grant/accept strobe; handshake completes on valid&ready
- bus  output  WIDTH  tri-state bus; per bit, held data if (DRIVE and mask bit=1), else 1'bz
- bus_valid  output  1  high in every DRIVE cycle
- bus_owner  output  max(1,$clog2(N_CH))  index of the last granted channel

## Operation
- States: IDLE, DRIVE, TURN.
- IDLE: if any req_valid, winner g = first asserted channel scanning ptr, ptr+1, … mod N_CH.
  - req_ready[g]=1, combinational, in IDLE only; all other ready bits 0.
  - At the clock edge: capture req_data/req_mask slice g into hold registers, bus_owner←g, ptr←(g+1) mod N_CH, cnt←HOLD-1, go to DRIVE.
  - No valid: stay in IDLE; ptr unchanged.
- DRIVE: bus drives held data on mask bits; bus_valid=1. If cnt=0: go to TURN with cnt←TURN-1 when TURN>0, otherwise go to IDLE. Else cnt←cnt-1.
- TURN: bus all Z, bus_valid=0. If cnt=0 go to IDLE, else cnt←cnt-1.
- The held word is immune to req_* changes after capture. A valid deasserted before its grant is simply not served.
- Mask all-zero: bus all Z during DRIVE, but bus_valid still 1 and the slot is consumed.
- The counter is $clog2(max(HOLD,TURN)+1) bits wide and never wraps past 0.
- N_CH=1: ptr is constant 0; channel 0 is granted whenever in IDLE with valid.

## Timing
- Reset, applied on the edge with rst=1: state=IDLE, ptr=0, cnt=0, hold data/mask=0, bus_owner=0, bus_valid=0, bus all Z, req_ready=0 in the cycle after reset.
  - While rst=1, req_ready is forced to 0.
- Reset mid-DRIVE or mid-TURN: the word is discarded with no retry; the bus is Z from the next cycle.
- Latency: grant in cycle t (IDLE) → bus driven in cycles t+1..t+HOLD → Z in t+HOLD+1..t+HOLD+TURN → IDLE at t+HOLD+TURN+1.
- Throughput per word: 1+HOLD+TURN cycles; the bus is never driven by two owners in consecutive cycles when TURN≥1.
- Simultaneous requests: exactly one grant per IDLE cycle. The ptr rotation guarantees each continuously-valid channel is served within N_CH grants.

## Test plan
- Reset: rst=1 for 3 cycles with random req_* inputs → bus=21'bz, bus_valid=0, req_ready=0, bus_owner=0 on the first cycle after release with no valid.
- Single request (WIDTH=21, N_CH=4, HOLD=2, TURN=1): ch2 data=32, mask=all ones, valid at cycle 0 → req_ready=4'b0100 in cycle 0; bus=32, bus_valid=1, bus_owner=2 in cycles 1–2; bus=Z in cycle 3; IDLE in cycle 4.
- Partial mask: ch0 data=64, mask=21'h40 → bus bit6=1 and all other bits Z during DRIVE; mask=0 → bus all Z with bus_valid=1.
- Round-robin: all four channels valid continuously, data=i+1 → grants 0,1,2,3,0 in cycles 0,4,8,12,16; bus shows 1,2,3,4,1.
- Reset mid-operation: assert rst in cycle 1 of ch3's DRIVE → bus Z from the next cycle; after release, ch1 and ch3 valid → ch1 granted first (ptr=0).
- TURN=0, HOLD=1: ch1 valid continuously → grant every 2 cycles; bus alternates driven and Z (IDLE cycle); no stale data appears after reset or discard.
